hour_bcd_counter: RTL and testbench

Parametrised modulo-N time-unit counter with binary, BCD and seven-segment outputs. It succeeds the fixed 0–23 hour path and serves as the hours, minutes or seconds stage of the digital clock. Stages are chained through `tick`/`carry`. Beyond plain counting, it adds:
- a synchronous load with range check,
- manual up/down adjust,
- a runtime 12/24-hour display mode with AM/PM flag,
- leading-zero blanking.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/hour_bcd_counter_if.sv | 39 +++
 rtl/hour_bcd_counter_bcd_to_seg7.sv | 33 +++
 rtl/hour_bcd_counter.sv | 132 +++++++++++++
 tb/tb_hour_bcd_counter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the digital-clock counter stages:
// active-low seven-segment patterns and a 0..99 binary to two-digit BCD converter.
package clock_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_ONE   = 7'h79;
    localparam logic [6:0] SEG_TWO   = 7'h24;
    localparam logic [6:0] SEG_THREE = 7'h30;
    localparam logic [6:0] SEG_FOUR  = 7'h19;
    localparam logic [6:0] SEG_FIVE  = 7'h12;
    localparam logic [6:0] SEG_SIX   = 7'h02;
    localparam logic [6:0] SEG_SEVEN = 7'h78;
    localparam logic [6:0] SEG_EIGHT = 7'h00;
    localparam logic [6:0] SEG_NINE  = 7'h10;

    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/hour_bcd_counter_if.sv
// Control/status bundle of one counter stage; the seven-segment signals exist
// only when HOUR_BCD_COUNTER_SEVSEG_EN is defined.
interface hour_bcd_counter_if #(parameter int VW = 7);

    logic          tick;
    logic          adj_up;
    logic          adj_down;
    logic          load;
    logic [VW-1:0] load_val;
    logic          mode12;

    logic [VW-1:0] value;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_ones;
    logic          pm;
    logic          carry;
    logic          load_err;
`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
    logic [6:0]    HEX_TENS;
    logic [6:0]    HEX_ONES;
`endif

    modport master (
        output tick, adj_up, adj_down, load, load_val, mode12,
        input  value, bcd_tens, bcd_ones, pm, carry, load_err
`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
        , input HEX_TENS, HEX_ONES
`endif
    );

    modport slave (
        input  tick, adj_up, adj_down, load, load_val, mode12,
        output value, bcd_tens, bcd_ones, pm, carry, load_err
`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
        , output HEX_TENS, HEX_ONES
`endif
    );

endinterface

// File: rtl/hour_bcd_counter_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking;
// non-digit codes decode to all segments off.
module bcd_to_seg7
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Digit pattern lookup, overridden by blanking
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_ZERO;
                4'd1:    seg = SEG_ONE;
                4'd2:    seg = SEG_TWO;
                4'd3:    seg = SEG_THREE;
                4'd4:    seg = SEG_FOUR;
                4'd5:    seg = SEG_FIVE;
                4'd6:    seg = SEG_SIX;
                4'd7:    seg = SEG_SEVEN;
                4'd8:    seg = SEG_EIGHT;
                4'd9:    seg = SEG_NINE;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hour_bcd_counter.sv
// Modulo-MODULUS time-unit counter with load, manual adjust, 12/24h display and
// registered BCD outputs; HOUR_BCD_COUNTER_SEVSEG_EN adds registered 7-seg outputs.
module hour_bcd_counter
    import clock_pkg::*;
#(
    parameter int MODULUS = 24,
    parameter int VW      = 7
)
(
    input  logic               signal_clk,
    input  logic               reset,
    hour_bcd_counter_if.slave  bus
);

    localparam logic [VW-1:0] MAX_VAL = VW'(MODULUS - 1);
    localparam logic [VW:0]   MOD_EXT = (VW+1)'(MODULUS);
    localparam logic          HOUR24  = (MODULUS == 24);

    logic [VW-1:0] value_d, value_q;
    logic          carry_d, carry_q;
    logic          load_err_d, load_err_q;
    logic          pm_d, pm_q;
    logic [3:0]    bcd_tens_d, bcd_tens_q;
    logic [3:0]    bcd_ones_d, bcd_ones_q;
    logic [6:0]    value7_s;
    logic [6:0]    disp_s;
    logic [7:0]    bcd_s;
    logic          mode12_s;

    // Next count: load beats a single adjust, which beats tick
    always_comb begin
        value_d    = value_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if ({1'b0, bus.load_val} < MOD_EXT) begin
                value_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.adj_up ^ bus.adj_down) begin
            if (bus.adj_up) begin
                value_d = (value_q == MAX_VAL) ? {VW{1'b0}} : value_q + VW'(1);
            end else begin
                value_d = (value_q == {VW{1'b0}}) ? MAX_VAL : value_q - VW'(1);
            end
        end else if (bus.tick) begin
            if (value_q == MAX_VAL) begin
                value_d = {VW{1'b0}};
                carry_d = 1'b1;
            end else begin
                value_d = value_q + VW'(1);
            end
        end else begin
            value_d = value_q;
        end
    end

    // Display mapping of the next value so digits stay coherent with the count
    always_comb begin
        value7_s = 7'(value_d);
        mode12_s = HOUR24 & bus.mode12;
        pm_d     = HOUR24 & (value7_s >= 7'd12);
        if (mode12_s) begin
            if (value7_s == 7'd0) begin
                disp_s = 7'd12;
            end else if (value7_s > 7'd12) begin
                disp_s = value7_s - 7'd12;
            end else begin
                disp_s = value7_s;
            end
        end else begin
            disp_s = value7_s;
        end
        bcd_s      = bin_to_bcd2(disp_s);
        bcd_tens_d = bcd_s[7:4];
        bcd_ones_d = bcd_s[3:0];
    end

    // Count and display state registers
    always_ff @(posedge signal_clk or posedge reset) begin
        if (reset) begin
            value_q    <= {VW{1'b0}};
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
            pm_q       <= 1'b0;
            bcd_tens_q <= 4'd0;
            bcd_ones_q <= 4'd0;
        end else begin
            value_q    <= value_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
            pm_q       <= pm_d;
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
    assign bus.pm       = pm_q;
    assign bus.bcd_tens = bcd_tens_q;
    assign bus.bcd_ones = bcd_ones_q;

`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
    logic       blank_s;
    logic [6:0] hex_tens_d, hex_tens_q;
    logic [6:0] hex_ones_d, hex_ones_q;

    // Leading zero suppressed only in 12h format
    assign blank_s = mode12_s & (bcd_tens_d == 4'd0);

    bcd_to_seg7 u_seg_tens (.bcd(bcd_tens_d), .blank(blank_s), .seg(hex_tens_d));
    bcd_to_seg7 u_seg_ones (.bcd(bcd_ones_d), .blank(1'b0),    .seg(hex_ones_d));

    // Segment output registers, reset shows "00"
    always_ff @(posedge signal_clk or posedge reset) begin
        if (reset) begin
            hex_tens_q <= SEG_ZERO;
            hex_ones_q <= SEG_ZERO;
        end else begin
            hex_tens_q <= hex_tens_d;
            hex_ones_q <= hex_ones_d;
        end
    end

    assign bus.HEX_TENS = hex_tens_q;
    assign bus.HEX_ONES = hex_ones_q;
`endif

endmodule

// File: tb/tb_hour_bcd_counter.sv
// Scoreboard bench for hour_bcd_counter: MODULUS=24 and MODULUS=60 instances,
// directed vectors with hand-computed expectations checked by per-DUT monitors.
module tb_hour_bcd_counter;

    typedef struct {
        int         v;
        int         t;
        int         o;
        logic       pm;
        logic       c;
        logic       e;
        logic [6:0] ht;
        logic [6:0] ho;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t q24[$];
    exp_t q60[$];

    hour_bcd_counter_if #(.VW(7)) b24 ();
    hour_bcd_counter_if #(.VW(7)) b60 ();

    hour_bcd_counter #(.MODULUS(24), .VW(7)) u24 (.signal_clk(clk), .reset(reset), .bus(b24));
    hour_bcd_counter #(.MODULUS(60), .VW(7)) u60 (.signal_clk(clk), .reset(reset), .bus(b60));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t mk(input int ev, et, eo, input logic epm, ec, ee, eblank,
                                input string nm);
        exp_t e;
        e.v = ev; e.t = et; e.o = eo; e.pm = epm; e.c = ec; e.e = ee;
        e.ht = eblank ? 7'h7F : seg(et);
        e.ho = seg(eo);
        e.name = nm;
        return e;
    endfunction

    task automatic snap(input bit sel, output exp_t a);
        if (sel) begin
            a.v = int'(b60.value); a.t = int'(b60.bcd_tens); a.o = int'(b60.bcd_ones);
            a.pm = b60.pm; a.c = b60.carry; a.e = b60.load_err;
`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
            a.ht = b60.HEX_TENS; a.ho = b60.HEX_ONES;
`else
            a.ht = 7'h00; a.ho = 7'h00;
`endif
        end else begin
            a.v = int'(b24.value); a.t = int'(b24.bcd_tens); a.o = int'(b24.bcd_ones);
            a.pm = b24.pm; a.c = b24.carry; a.e = b24.load_err;
`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
            a.ht = b24.HEX_TENS; a.ho = b24.HEX_ONES;
`else
            a.ht = 7'h00; a.ho = 7'h00;
`endif
        end
        a.name = "";
    endtask

    task automatic cmp(input exp_t e, input exp_t a);
        bit bad;
        vectors++;
        bad = (a.v != e.v) || (a.t != e.t) || (a.o != e.o) ||
              (a.pm !== e.pm) || (a.c !== e.c) || (a.e !== e.e);
`ifdef HOUR_BCD_COUNTER_SEVSEG_EN
        bad = bad || (a.ht !== e.ht) || (a.ho !== e.ho);
`endif
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got v=%0d bcd=%0d/%0d pm=%b c=%b err=%b hex=%h/%h, expected v=%0d bcd=%0d/%0d pm=%b c=%b err=%b hex=%h/%h",
                     e.name, a.v, a.t, a.o, a.pm, a.c, a.e, a.ht, a.ho,
                     e.v, e.t, e.o, e.pm, e.c, e.e, e.ht, e.ho);
        end
    endtask

    // Drive one cycle of stimulus on the selected DUT and queue its expected response
    task automatic step(input bit sel, input logic tk, au, ad, ld, input int lv, input logic m12,
                        input int ev, et, eo, input logic epm, ec, ee, eblank, input string nm);
        @(negedge clk);
        b24.tick = 1'b0; b24.adj_up = 1'b0; b24.adj_down = 1'b0; b24.load = 1'b0;
        b60.tick = 1'b0; b60.adj_up = 1'b0; b60.adj_down = 1'b0; b60.load = 1'b0;
        if (sel) begin
            b60.tick = tk; b60.adj_up = au; b60.adj_down = ad; b60.load = ld;
            b60.load_val = 7'(lv); b60.mode12 = m12;
            q60.push_back(mk(ev, et, eo, epm, ec, ee, eblank, nm));
        end else begin
            b24.tick = tk; b24.adj_up = au; b24.adj_down = ad; b24.load = ld;
            b24.load_val = 7'(lv); b24.mode12 = m12;
            q24.push_back(mk(ev, et, eo, epm, ec, ee, eblank, nm));
        end
    endtask

    // Monitor for the 24-hour instance
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q24.size() > 0) begin
                e = q24.pop_front();
                snap(1'b0, a);
                cmp(e, a);
            end
        end
    end

    // Monitor for the 60-count instance
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q60.size() > 0) begin
                e = q60.pop_front();
                snap(1'b1, a);
                cmp(e, a);
            end
        end
    end

    initial begin
        exp_t a;
        int   budget;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        b24.tick = 1'b0; b24.adj_up = 1'b0; b24.adj_down = 1'b0; b24.load = 1'b0;
        b24.load_val = 7'd0; b24.mode12 = 1'b0;
        b60.tick = 1'b0; b60.adj_up = 1'b0; b60.adj_down = 1'b0; b60.load = 1'b0;
        b60.load_val = 7'd0; b60.mode12 = 1'b0;

        #12;
        snap(1'b0, a); cmp(mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_24"), a);
        snap(1'b1, a); cmp(mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_60"), a);
        @(negedge clk);
        reset = 1'b0;

        // Count up through the full hour range, then wrap
        for (int k = 1; k <= 23; k++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, k, k / 10, k % 10, (k >= 12), 1'b0, 1'b0, 1'b0, "t1_count");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "t1_wrap_carry");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_carry_one_cycle");

        // 12-hour display mapping
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b1, 0,  1, 2, 1'b0, 1'b0, 1'b0, 1'b0, "t2_load0_12h");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13, 1'b1, 13, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, "t2_load13_12h");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12, 1'b1, 12, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, "t2_load12_12h");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15, 1'b1, 15, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1, "t2_load15_12h");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 15, 1, 5, 1'b1, 1'b0, 1'b0, 1'b0, "t2_mode_toggle");

        // Load range check and priority
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 30, 1'b0, 15, 1, 5, 1'b1, 1'b0, 1'b1, 1'b0, "t3_load_err30");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 15, 1, 5, 1'b1, 1'b0, 1'b0, 1'b0, "t3_err_one_cycle");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24, 1'b0, 15, 1, 5, 1'b1, 1'b0, 1'b1, 1'b0, "t3_load_err24");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5,  1'b0, 5,  0, 5, 1'b0, 1'b0, 1'b0, 1'b0, "t3_load_over_tick_adj");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23, 1'b0, 23, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0, "t3_load23_no_carry");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t3_adj_wrap_no_carry");

        // Manual adjust
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 23, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0, "t4_down_wrap");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_up_wrap");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1,  0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "t4_both_adj_tick");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_down_to_zero");

        // MODULUS=60 with mode12 held high, which must be ignored
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 58, 1'b1, 58, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0, "t5_load58");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 59, 5, 9, 1'b0, 1'b0, 1'b0, 1'b0, "t5_tick59");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 0,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "t5_wrap60");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 60, 1'b1, 0,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_load_err60");

        // Asynchronous reset mid-count, with mode12 high
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 16, 0, 4, 1'b1, 1'b0, 1'b0, 1'b1, "t6_load16");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 17, 0, 5, 1'b1, 1'b0, 1'b0, 1'b1, "t6_tick17");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        snap(1'b0, a); cmp(mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_async_reset_24"), a);
        snap(1'b1, a); cmp(mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_async_reset_60"), a);
        b24.tick = 1'b1;
        b24.load = 1'b1;
        b24.load_val = 7'd9;
        @(posedge clk);
        #1;
        snap(1'b0, a); cmp(mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_inputs_ignored"), a);
        @(negedge clk);
        b24.load = 1'b0;
        b24.tick = 1'b0;
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, "t6_resume");

        budget = 0;
        while ((q24.size() > 0 || q60.size() > 0) && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q24.size() > 0 || q60.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", q24.size() + q60.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
